acc_breg_sequencer: RTL and testbench
=====================================

Name: acc_breg_sequencer

Overview:
- Operand/writeback stage directly upstream of the registered 8-bit ALU.
- Owns the accumulator and B register and drives the ALU's ACC_IN, BREG_IN and OP inputs.
- Accepts one operation request at a time from the control unit, waits out the ALU's registered latency, then writes ALU_OUT back into the accumulator and updates the Z/N flags.
- Also provides a direct accumulator load from the bus.

Parameters:
WIDTH, 8, datapath width; must match the ALU (8).
ALU_LATENCY, 1, clock edges between stable ALU inputs and a valid ALU result; legal range 1..4.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-high
BUS_IN  input  WIDTH  operand or load data from the bus
ACC_LOAD  input  1  load accumulator from BUS_IN (IDLE only)
REQ_VALID  input  1  operation request
REQ_OP  input  3  ALU op code: 000 ADD, 001 SUB, 010 DEC, 011 INC, 100 OC, 101 AND, 110 OR, 111 XOR
REQ_READY  output  1  request accepted on an edge where REQ_VALID && REQ_READY
ALU_RESULT  input  WIDTH  from ALU ALU_OUT
ACC_OUT  output  WIDTH  accumulator; to ALU ACC_IN and to the bus
BREG_OUT  output  WIDTH  B register; to ALU BREG_IN
ALU_OP  output  3  registered op code; to ALU OP
DONE  output  1  one-cycle pulse after writeback
BUSY  output  1  high when the FSM is not in IDLE
FLAG_Z  output  1  accumulator == 0
FLAG_N  output  1  accumulator bit WIDTH-1

Behaviour:
- Reset is asynchronous, active-high. While RST is high: state=IDLE, ACC_OUT=0, BREG_OUT=0, ALU_OP=000, DONE=0, FLAG_Z=1, FLAG_N=0, latency counter=0.
- Reset mid-operation aborts the operation with no writeback and no DONE.
- FSM states: IDLE, EXEC, WB.
- REQ_READY = (state==IDLE) && !ACC_LOAD. It is combinational.
- BUSY = (state!=IDLE). It is combinational.
- IDLE with ACC_LOAD=1: ACC <= BUS_IN and flags recomputed from BUS_IN; state stays IDLE.
- ACC_LOAD has priority over REQ_VALID in the same cycle; the request is not accepted and must be held.
- IDLE with a handshake at edge k:
  - ALU_OP <= REQ_OP; counter <= 0; state -> EXEC.
  - Binary ops (ADD, SUB, AND, OR, XOR): BREG <= BUS_IN.
  - Unary ops (DEC, INC, OC): BREG is unchanged.
- EXEC: ACC_OUT, BREG_OUT and ALU_OP are held stable. The counter increments each edge. When counter==ALU_LATENCY-1 the state moves to WB, at edge k+ALU_LATENCY.
- WB: at edge k+ALU_LATENCY+1:
  - ACC <= ALU_RESULT.
  - FLAG_Z <= (ALU_RESULT==0); FLAG_N <= ALU_RESULT[WIDTH-1].
  - DONE <= 1; state -> IDLE.
- DONE is high for exactly the one cycle after writeback. REQ_READY is high in that same cycle, so back-to-back requests are accepted. Throughput is one op per ALU_LATENCY+2 cycles; with ALU_LATENCY=1, one op per 3 cycles.
- ACC_LOAD and REQ_VALID are ignored outside IDLE; no state changes result.
- Arithmetic is performed by the ALU. This block only captures results: wrap-around (e.g. 0xFF+1=0x00) is taken verbatim, and there is no carry or overflow flag.
- ALU_OP holds its last value while in IDLE. The ALU keeps clocking, but ALU_RESULT is sampled only in WB.
- Flags change only on ACC_LOAD, writeback, or reset.

Test Plan:
1. ACC_LOAD with BUS_IN=0x05, then ADD with BUS_IN=0x03 (ALU_LATENCY=1) -> BREG_OUT=0x03 after handshake; ACC_OUT=0x08 two edges later; DONE one cycle; Z=0, N=0; REQ_READY low for two cycles.
2. ACC=0x08; SUB with BUS_IN=0x08 -> ACC=0x00, Z=1, N=0. Then DEC -> ACC=0xFF, Z=0, N=1. Then INC -> ACC=0x00, Z=1 (wrap).
3. BREG=0x03; INC with BUS_IN=0x55 -> BREG_OUT remains 0x03; ACC increments by 1.
4. In IDLE, ACC_LOAD=1 with BUS_IN=0x7F and REQ_VALID=1 (XOR) in the same cycle -> ACC=0x7F, REQ_READY=0, no handshake. Next cycle with ACC_LOAD=0 -> XOR accepted.
5. RST pulsed asynchronously mid-EXEC with ACC=0x42 -> ACC_OUT=0, BREG_OUT=0, ALU_OP=000, Z=1, N=0, BUSY=0 immediately; no DONE follows.
6. ALU_LATENCY=3, back-to-back ADD requests with REQ_VALID held -> each DONE 5 cycles apart. Second handshake lands on the DONE cycle; second result uses the first written-back ACC.

Source files
------------

// File: rtl/acc_breg_sequencer_if.sv
// Control-unit / ALU side signals of the accumulator and B-register sequencer.
// The slave modport is the sequencer. The master modport is the control unit and ALU.
interface acc_breg_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] BUS_IN;
  logic             ACC_LOAD;
  logic             REQ_VALID;
  logic [2:0]       REQ_OP;
  logic             REQ_READY;
  logic [WIDTH-1:0] ALU_RESULT;
  logic [WIDTH-1:0] ACC_OUT;
  logic [WIDTH-1:0] BREG_OUT;
  logic [2:0]       ALU_OP;
  logic             DONE;
  logic             BUSY;
  logic             FLAG_Z;
  logic             FLAG_N;

  modport master (
    output BUS_IN, ACC_LOAD, REQ_VALID, REQ_OP, ALU_RESULT,
    input  REQ_READY, ACC_OUT, BREG_OUT, ALU_OP, DONE, BUSY, FLAG_Z, FLAG_N
  );

  modport slave (
    input  BUS_IN, ACC_LOAD, REQ_VALID, REQ_OP, ALU_RESULT,
    output REQ_READY, ACC_OUT, BREG_OUT, ALU_OP, DONE, BUSY, FLAG_Z, FLAG_N
  );
endinterface

// File: rtl/acc_breg_sequencer.sv
// Operand/writeback stage in front of the registered ALU. It owns ACC and BREG, waits out the
// ALU latency for each request, and then writes ALU_RESULT back into ACC.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accept ACC_LOAD or one op request
// S_EXEC | ALU inputs held stable while the latency counter runs
// S_WB   | capture ALU_RESULT into ACC, update flags, pulse DONE
module acc_breg_sequencer #(
  parameter int WIDTH       = 8,
  parameter int ALU_LATENCY = 1
) (
  input logic                 CLK,
  input logic                 RST,
  acc_breg_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] LAT_LAST = 3'(ALU_LATENCY - 1);

  localparam logic [2:0] OP_DEC = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_OC  = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             req_unary;

  assign req_unary = (bus.REQ_OP == OP_DEC) || (bus.REQ_OP == OP_INC) ||
                     (bus.REQ_OP == OP_OC);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    breg_d   = breg_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    case (state_q)
      S_IDLE: begin
        // ACC_LOAD wins over a request in the same cycle. The request stays pending.
        if (bus.ACC_LOAD) begin
          acc_d    = bus.BUS_IN;
          flag_z_d = (bus.BUS_IN == '0);
          flag_n_d = bus.BUS_IN[WIDTH-1];
        end else if (bus.REQ_VALID) begin
          op_d    = bus.REQ_OP;
          cnt_d   = '0;
          state_d = S_EXEC;
          if (!req_unary) begin
            breg_d = bus.BUS_IN;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT_LAST) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        acc_d    = bus.ALU_RESULT;
        flag_z_d = (bus.ALU_RESULT == '0);
        flag_n_d = bus.ALU_RESULT[WIDTH-1];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      breg_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      flag_z_q <= 1'b1;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      breg_q   <= breg_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign bus.REQ_READY = (state_q == S_IDLE) && !bus.ACC_LOAD;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.ACC_OUT   = acc_q;
  assign bus.BREG_OUT  = breg_q;
  assign bus.ALU_OP    = op_q;
  assign bus.DONE      = done_q;
  assign bus.FLAG_Z    = flag_z_q;
  assign bus.FLAG_N    = flag_n_q;

endmodule

// File: tb/tb_acc_breg_sequencer.sv
// Scoreboard bench for acc_breg_sequencer. It has one instance with a 1-cycle ALU and one with a
// 3-cycle ALU, each fed by a behavioural registered ALU.
module tb_acc_breg_sequencer;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, DEC = 3'b010, INC = 3'b011,
                         OC  = 3'b100, AND = 3'b101, OR  = 3'b110, XOR = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_breg_sequencer_if #(.WIDTH(8)) if1 ();
  acc_breg_sequencer_if #(.WIDTH(8)) if3 ();

  acc_breg_sequencer #(.WIDTH(8), .ALU_LATENCY(1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));
  acc_breg_sequencer #(.WIDTH(8), .ALU_LATENCY(3)) dut3 (.CLK(clk), .RST(rst), .bus(if3));

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [7:0] m_acc1 = 8'h00, m_breg1 = 8'h00;
  logic [7:0] m_acc3 = 8'h00;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      DEC:     return a - 8'd1;
      INC:     return a + 8'd1;
      OC:      return ~a;
      AND:     return a & b;
      OR:      return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_bin(input logic [2:0] op);
    return !(op == DEC || op == INC || op == OC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural registered ALUs with 1- and 3-cycle pipelines.
  logic [7:0] p1 = 8'h00;
  logic [7:0] p3 [3] = '{8'h00, 8'h00, 8'h00};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= alu_f(if1.ACC_OUT, if1.BREG_OUT, if1.ALU_OP);
    p3[0] <= alu_f(if3.ACC_OUT, if3.BREG_OUT, if3.ALU_OP);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if1.ALU_RESULT = p1;
  assign if3.ALU_RESULT = p3[2];

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && if1.DONE) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("wb1_acc", if1.ACC_OUT, e);
        chk("wb1_z", if1.FLAG_Z, (e == 8'h00));
        chk("wb1_n", if1.FLAG_N, e[7]);
        chk("wb1_ready", if1.REQ_READY, 1);
      end
    end
  end

  int last_done3 = -1;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && if3.DONE) begin
      if (q3.size() == 0) chk("done3_unexpected", 1, 0);
      else begin
        e = q3.pop_front();
        chk("wb3_acc", if3.ACC_OUT, e);
        chk("wb3_z", if3.FLAG_Z, (e == 8'h00));
        chk("wb3_n", if3.FLAG_N, e[7]);
        chk("wb3_ready", if3.REQ_READY, 1);
        if (last_done3 >= 0) chk("done3_gap", cyc - last_done3, 5);
        last_done3 = cyc;
      end
    end
  end

  task automatic load1(input logic [7:0] d);
    @(negedge clk);
    if1.ACC_LOAD = 1'b1;
    if1.BUS_IN   = d;
    @(negedge clk);
    if1.ACC_LOAD = 1'b0;
    m_acc1 = d;
    chk("load_acc", if1.ACC_OUT, d);
    chk("load_z", if1.FLAG_Z, (d == 8'h00));
    chk("load_n", if1.FLAG_N, d[7]);
    chk("load_busy", if1.BUSY, 0);
  endtask

  task automatic op1(input logic [2:0] op, input logic [7:0] d);
    logic [7:0] exp;
    int n;
    @(negedge clk);
    if1.REQ_VALID = 1'b1;
    if1.REQ_OP    = op;
    if1.BUS_IN    = d;
    #1;
    chk("ready_idle", if1.REQ_READY, 1);
    if (is_bin(op)) m_breg1 = d;
    exp = alu_f(m_acc1, m_breg1, op);
    m_acc1 = exp;
    q1.push_back(exp);
    @(negedge clk);
    if1.REQ_VALID = 1'b0;
    if1.BUS_IN    = 8'hA5;
    chk("exec_breg", if1.BREG_OUT, m_breg1);
    chk("exec_op", if1.ALU_OP, op);
    chk("exec_busy", if1.BUSY, 1);
    n = 1;
    while (!if1.DONE && n < 12) begin
      chk("ready_busy", if1.REQ_READY, 0);
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 3);
  endtask

  initial begin
    int hs;
    if1.BUS_IN = 8'h00; if1.ACC_LOAD = 1'b0; if1.REQ_VALID = 1'b0; if1.REQ_OP = 3'b000;
    if3.BUS_IN = 8'h00; if3.ACC_LOAD = 1'b0; if3.REQ_VALID = 1'b0; if3.REQ_OP = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_acc", if1.ACC_OUT, 0);
    chk("rst_breg", if1.BREG_OUT, 0);
    chk("rst_op", if1.ALU_OP, 0);
    chk("rst_done", if1.DONE, 0);
    chk("rst_z", if1.FLAG_Z, 1);
    chk("rst_n", if1.FLAG_N, 0);
    chk("rst_busy", if1.BUSY, 0);
    rst = 1'b0;

    load1(8'h05);
    op1(ADD, 8'h03);
    op1(SUB, 8'h08);
    op1(DEC, 8'h00);
    op1(INC, 8'h00);
    op1(ADD, 8'h03);
    op1(INC, 8'h55);
    op1(OC, 8'h00);
    op1(AND, 8'hF0);
    op1(OR, 8'h81);

    // ACC_LOAD and a request in the same cycle: the load wins and the request waits.
    @(negedge clk);
    if1.ACC_LOAD  = 1'b1;
    if1.BUS_IN    = 8'h7F;
    if1.REQ_VALID = 1'b1;
    if1.REQ_OP    = XOR;
    #1;
    chk("prio_ready", if1.REQ_READY, 0);
    @(negedge clk);
    if1.ACC_LOAD  = 1'b0;
    if1.REQ_VALID = 1'b0;
    m_acc1 = 8'h7F;
    chk("prio_acc", if1.ACC_OUT, 8'h7F);
    chk("prio_busy", if1.BUSY, 0);
    op1(XOR, 8'h0F);

    // Asynchronous reset in the middle of EXEC.
    load1(8'h42);
    @(negedge clk);
    if1.REQ_VALID = 1'b1;
    if1.REQ_OP    = ADD;
    if1.BUS_IN    = 8'h01;
    @(negedge clk);
    if1.REQ_VALID = 1'b0;
    chk("abort_busy_pre", if1.BUSY, 1);
    rst = 1'b1;
    #1;
    chk("abort_acc", if1.ACC_OUT, 0);
    chk("abort_breg", if1.BREG_OUT, 0);
    chk("abort_op", if1.ALU_OP, 0);
    chk("abort_z", if1.FLAG_Z, 1);
    chk("abort_n", if1.FLAG_N, 0);
    chk("abort_busy", if1.BUSY, 0);
    #1;
    rst = 1'b0;
    m_acc1 = 8'h00;
    m_breg1 = 8'h00;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", if1.DONE, 0);
    end

    // Back-to-back requests on the 3-cycle ALU instance, with REQ_VALID held.
    @(negedge clk);
    if3.ACC_LOAD = 1'b1;
    if3.BUS_IN   = 8'h10;
    @(negedge clk);
    if3.ACC_LOAD = 1'b0;
    m_acc3 = 8'h10;
    chk("l3_acc", if3.ACC_OUT, 8'h10);
    if3.REQ_OP    = ADD;
    if3.BUS_IN    = 8'h05;
    if3.REQ_VALID = 1'b1;
    hs = 0;
    for (int c = 0; c < 60 && (hs < 3 || q3.size() > 0); c++) begin
      #1;
      if (hs == 3) if3.REQ_VALID = 1'b0;
      else if (if3.REQ_READY) begin
        m_acc3 = m_acc3 + 8'h05;
        q3.push_back(m_acc3);
        hs++;
      end
      @(negedge clk);
    end
    if3.REQ_VALID = 1'b0;
    chk("b2b_handshakes", hs, 3);
    chk("b2b_q3_empty", q3.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("b2b_final_acc", if3.ACC_OUT, 8'h1F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
